// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: widths, memory depth,
// loader state encoding and the word-count decode helper.
package imem_pkg;

  localparam int ADDR_W     = 8;    // instruction memory address width
  localparam int DATA_W     = 16;   // instruction word width (two bytes)
  localparam int IMEM_DEPTH = 256;  // number of instruction words
  localparam int BYTE_W     = 8;    // stream byte width
  localparam int CNT_W      = 9;    // remaining-word counter width (holds 256)

  // Loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5
  } loader_state_e;

  // A count byte of zero stands for a full memory image.
  function automatic logic [CNT_W-1:0] decode_count(input logic [BYTE_W-1:0] n);
    if (n == '0) begin
      return CNT_W'(IMEM_DEPTH);
    end
    return {1'b0, n};
  endfunction

endpackage

// File: rtl/imem_loader_chk_xor8.sv
// Running XOR accumulator over stream bytes, used to verify the trailing
// checksum byte of a program image.
module imem_chk_xor8
  import imem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [BYTE_W-1:0] o_acc
);

  logic [BYTE_W-1:0] r_acc;

  // Accumulate XOR of enabled bytes; clear wins over enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_byte;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/imem_loader.sv
// Program loader: fills the 256 x 16-bit instruction memory from a byte
// stream (count byte, then big-endian words) and holds the CPU while loading.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [BYTE_W-1:0] i_byte_data,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err
);

  loader_state_e r_state;
  loader_state_e w_state_next;

  logic              w_ready;
  logic              w_hold;
  logic              w_xfer;
  logic              w_start_load;
  logic              w_last_word;

  logic [CNT_W-1:0]  r_remaining;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_done;

  assign w_xfer       = w_ready & i_byte_valid;
  // start only counts when no load is in flight
  assign w_start_load = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_last_word  = (r_remaining == CNT_W'(1));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus handshake/hold outputs, both purely state-driven.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_hold       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_next = ST_COUNT;
        end
      end
      ST_COUNT: begin
        w_ready = 1'b1;
        w_hold  = 1'b1;
        if (w_xfer) begin
          w_state_next = ST_HI;
        end
      end
      ST_HI: begin
        w_ready = 1'b1;
        w_hold  = 1'b1;
        if (w_xfer) begin
          w_state_next = ST_LO;
        end
      end
      ST_LO: begin
        w_ready = 1'b1;
        w_hold  = 1'b1;
        if (w_xfer) begin
          if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_state_next = ST_CHK;
`else
            w_state_next = ST_DONE;
`endif
          end else begin
            w_state_next = ST_HI;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        w_ready = 1'b1;
        w_hold  = 1'b1;
        if (w_xfer) begin
          w_state_next = ST_DONE;
        end
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Word assembly, write strobe, address and word counting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_remaining <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      // strobe fires the cycle after the low byte lands
      r_wr_en <= (r_state == ST_LO) & w_xfer;

      // address advances once the write it qualified has been issued;
      // an 8-bit counter wraps to 0 after a full image
      if (w_start_load) begin
        r_wr_addr <= '0;
      end else if (r_wr_en) begin
        r_wr_addr <= r_wr_addr + ADDR_W'(1);
      end

      if (w_start_load) begin
        r_remaining <= '0;
      end else if (w_xfer) begin
        case (r_state)
          ST_COUNT: r_remaining <= decode_count(i_byte_data);
          ST_HI:    r_wr_data[DATA_W-1:BYTE_W] <= i_byte_data;
          ST_LO: begin
            r_wr_data[BYTE_W-1:0] <= i_byte_data;
            r_remaining           <= r_remaining - CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic              r_err;
  logic              w_chk_en;
  logic [BYTE_W-1:0] w_chk_acc;

  // only word bytes feed the checksum; the count byte is excluded
  assign w_chk_en = w_xfer & ((r_state == ST_HI) | (r_state == ST_LO));

  imem_chk_xor8 u_chk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_start_load),
    .i_en    (w_chk_en),
    .i_byte  (i_byte_data),
    .o_acc   (w_chk_acc)
  );

  // Completion flags: verdict taken when the checksum byte is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_start_load) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else if ((r_state == ST_CHK) && w_xfer) begin
      if (i_byte_data == w_chk_acc) begin
        r_done <= 1'b1;
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;
`else
  // Completion flag: set as the low byte of the last word is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done <= 1'b0;
    end else if (w_start_load) begin
      r_done <= 1'b0;
    end else if ((r_state == ST_LO) && w_xfer && w_last_word) begin
      r_done <= 1'b1;
    end
  end

  assign o_err = 1'b0;
`endif

  assign o_byte_ready = w_ready;
  assign o_cpu_hold   = w_hold;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_done       = r_done;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, mid-load reset, small and full-size
// loads, stalled stream with ignored start, and checksum/no-checksum endings.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  log_addr[$];
  logic [15:0] log_data[$];

  imem_loader dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_byte_valid (byte_valid),
    .i_byte_data  (byte_data),
    .o_byte_ready (byte_ready),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_cpu_hold   (cpu_hold),
    .o_done       (done),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every memory write seen on the falling edge
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // present one byte, optionally after random idle cycles; returns #1 after
  // the accepting edge
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    int waited;
    if (stall) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        byte_valid = 1'b0;
        step();
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    waited     = 0;
    while (byte_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (waited >= 20) begin
      chk("byte_ready_timeout", 32'(waited), 32'd0);
    end
    step();
    byte_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  logic [7:0]  xor_acc;
  logic [15:0] exp_words[3];

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    step();
    step();

    // reset values
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_wr_en",      32'(wr_en),      32'd0);
    chk("rst_wr_addr",    32'(wr_addr),    32'd0);
    chk("rst_wr_data",    32'(wr_data),    32'd0);
    chk("rst_cpu_hold",   32'(cpu_hold),   32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_err",        32'(err),        32'd0);
    rst_n = 1'b1;
    step();

    // reset in the middle of a load
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
    chk("midrst_wr_en",      32'(wr_en),      32'd0);
    chk("midrst_wr_data",    32'(wr_data),    32'd0);
    chk("midrst_cpu_hold",   32'(cpu_hold),   32'd0);
    chk("midrst_done",       32'(done),       32'd0);
    step();
    rst_n = 1'b1;
    step();

    // N=2: 0x4C05, 0xFC00 at one byte per cycle
    clear_log();
    pulse_start();
    chk("n2_hold_after_start",  32'(cpu_hold),   32'd1);
    chk("n2_ready_after_start", 32'(byte_ready), 32'd1);
    send_byte(8'h02, 1'b0);
    send_byte(8'h4C, 1'b0);
    send_byte(8'h05, 1'b0);
    chk("n2_w0_wr_en", 32'(wr_en),   32'd1);
    chk("n2_w0_addr",  32'(wr_addr), 32'd0);
    chk("n2_w0_data",  32'(wr_data), 32'h4C05);
    send_byte(8'hFC, 1'b0);
    chk("n2_w1hi_wr_en", 32'(wr_en),   32'd0);
    chk("n2_w1hi_addr",  32'(wr_addr), 32'd1);
    send_byte(8'h00, 1'b0);
    chk("n2_w1_wr_en", 32'(wr_en),   32'd1);
    chk("n2_w1_addr",  32'(wr_addr), 32'd1);
    chk("n2_w1_data",  32'(wr_data), 32'hFC00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("n2_hold_before_chk", 32'(cpu_hold), 32'd1);
    send_byte(8'hB5, 1'b0);
`endif
    chk("n2_done",  32'(done),       32'd1);
    chk("n2_err",   32'(err),        32'd0);
    chk("n2_hold",  32'(cpu_hold),   32'd0);
    chk("n2_ready", 32'(byte_ready), 32'd0);
    step();
    chk("n2_log_size", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk("n2_log0_addr", 32'(log_addr[0]), 32'd0);
      chk("n2_log0_data", 32'(log_data[0]), 32'h4C05);
      chk("n2_log1_addr", 32'(log_addr[1]), 32'd1);
      chk("n2_log1_data", 32'(log_data[1]), 32'hFC00);
    end

    // N=0 means 256 words, word value equals its address
    clear_log();
    xor_acc = 8'h00;
    pulse_start();
    chk("n256_done_cleared", 32'(done), 32'd0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h00, 1'b0);
      send_byte(8'(i), 1'b0);
      xor_acc = xor_acc ^ 8'(i);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xor_acc, 1'b0);
`endif
    chk("n256_done", 32'(done), 32'd1);
    step();
    chk("n256_addr_wrap", 32'(wr_addr), 32'd0);
    chk("n256_wr_en_idle", 32'(wr_en), 32'd0);
    chk("n256_log_size", 32'(log_addr.size()), 32'd256);
    for (int i = 0; i < 256 && i < log_addr.size(); i++) begin
      chk($sformatf("n256_addr_%0d", i), 32'(log_addr[i]), 32'(i));
      chk($sformatf("n256_data_%0d", i), 32'(log_data[i]), 32'(i));
    end

    // stalled stream with a start pulse in the middle of the load
    clear_log();
    exp_words[0] = 16'hA5A5;
    exp_words[1] = 16'h0102;
    exp_words[2] = 16'hBEEF;
    pulse_start();
    send_byte(8'h03, 1'b1);
    send_byte(8'hA5, 1'b1);
    pulse_start();
    chk("stall_hold_after_start",  32'(cpu_hold),   32'd1);
    chk("stall_ready_after_start", 32'(byte_ready), 32'd1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h52, 1'b1);
`endif
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_hold", 32'(cpu_hold), 32'd0);
    step();
    chk("stall_log_size", 32'(log_addr.size()), 32'd3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      chk($sformatf("stall_addr_%0d", i), 32'(log_addr[i]), 32'(i));
      chk($sformatf("stall_data_%0d", i), 32'(log_data[i]), 32'(exp_words[i]));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // good checksum
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h4C, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h49, 1'b0);
    chk("chk_good_done", 32'(done), 32'd1);
    chk("chk_good_err",  32'(err),  32'd0);
    // bad checksum: write still happens, err instead of done
    clear_log();
    pulse_start();
    chk("chk_bad_done_cleared", 32'(done), 32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h4C, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("chk_bad_err",  32'(err),      32'd1);
    chk("chk_bad_done", 32'(done),     32'd0);
    chk("chk_bad_hold", 32'(cpu_hold), 32'd0);
    step();
    chk("chk_bad_log_size", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      chk("chk_bad_log_data", 32'(log_data[0]), 32'h4C05);
    end
`else
    // no checksum: done together with the final write strobe
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    chk("nochk_wr_en", 32'(wr_en),      32'd1);
    chk("nochk_addr",  32'(wr_addr),    32'd0);
    chk("nochk_data",  32'(wr_data),    32'h1234);
    chk("nochk_done",  32'(done),       32'd1);
    chk("nochk_err",   32'(err),        32'd0);
    chk("nochk_ready", 32'(byte_ready), 32'd0);
    chk("nochk_hold",  32'(cpu_hold),   32'd0);
    step();
    chk("nochk_wr_en_single", 32'(wr_en), 32'd0);
    chk("nochk_err_later",    32'(err),   32'd0);
    chk("nochk_done_held",    32'(done),  32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the 256 x 16-bit instruction memory from a byte-wide stream before the processor runs. It accepts a valid/ready byte stream (word count, then big-endian instruction words), drives the instruction memory write port with sequential addresses from 0, and holds the CPU in reset/stall while loading. It sits between the external download interface and the instruction memory write side.

## Interface
- ADDR_W, 8, instruction memory address width
- DATA_W, 16, instruction word width (two bytes, fixed)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load when idle or done
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  instruction memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- cpu_hold  out  1  high while a load is in progress; CPU must not fetch
- done  out  1  load completed successfully; held until next start
- err  out  1  load failed (checksum); held until next start

## Operation
- Byte transfer occurs on a rising edge with byte_valid && byte_ready.
- Stream format: byte 0 = word count N (0 encodes 256); then N words, high byte first, low byte second; then one checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
- States: IDLE, COUNT, HI, LO, CHK, DONE.
- IDLE/DONE: start -> COUNT; clear done, err, address counter, checksum; cpu_hold rises.
- COUNT: accept N; remaining (9-bit) = N or 256 -> HI.
- HI: accept byte into wr_data[15:8] -> LO.
- LO: accept byte into wr_data[7:0]; next cycle wr_en=1 with current wr_addr; then wr_addr increments; remaining decrements. If remaining becomes 0 -> CHK (macro defined) or DONE; else -> HI.
- CHK: accept checksum byte; compare -> DONE with done=1, or DONE with err=1.
- byte_ready = 1 in COUNT, HI, LO, CHK only.
- start while in COUNT/HI/LO/CHK is ignored.
- wr_addr after a 256-word load wraps to 0; no extra write issued.
- Instruction memory contents are never cleared by this block.

## Timing
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0, state IDLE.
- start sampled high -> cpu_hold=1 and byte_ready=1 from the next cycle.
- wr_en: exactly one cycle, the cycle after the low byte is accepted; wr_addr/wr_data stable while wr_en=1.
- Back-to-back words: one byte per cycle sustained; the wr_en for word k overlaps the HI acceptance of word k+1.
- done/err and cpu_hold=0 take effect in the cycle after the final byte (last LO or CHK) is accepted; without the checksum, the final wr_en is in that same cycle.
- rst_n low mid-load: immediate return to reset values; partial load abandoned.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: running XOR of all word bytes (count byte excluded); the CHK state expects one trailing byte equal to it; mismatch sets err, done stays 0.
- Not defined: CHK state and XOR logic are absent; err is tied 0; done follows the last word.

## Structure
- Shared package imem_pkg: ADDR_W, DATA_W, IMEM_DEPTH=256, loader state enum.
- One sub-module: imem_chk_xor8 (clear, enable, byte in, 8-bit XOR accumulator), instantiated only under IMEM_LOADER_CHECKSUM_EN.

## Test plan
- Reset mid-load: rst_n low after 3 bytes -> all outputs 0 immediately; a fresh start loads correctly from address 0.
- N=2, words 0x4C05, 0xFC00, one byte per cycle -> wr_en at addr 0 with 0x4C05 and addr 1 with 0xFC00; done=1, cpu_hold=0.
- N=0 (256 words, data = address) -> 256 writes, addresses 0..255; final wr_addr wraps to 0; done=1.
- byte_valid toggled randomly, with start pulsed during the load -> same writes as the no-stall case; the start is ignored.
- Checksum (macro defined): N=1, 0x4C05, checksum 0x49 -> done=1; checksum 0x00 -> err=1, done=0, write still issued.
- Macro undefined: N=1, 0x1234 -> done in the cycle after the low byte; err stays 0; byte_ready drops to 0.
